mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 16-bit two-register memory block. It accepts independent read/write requests from two requesters and grants the memory to one at a time, round-robin by default. It drives the memory's select, write-enable and data-in, and captures its data-out for reads. It sits between the memory instance and its clients, so no client ever drives the memory directly.

---
 rtl/mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer in front of the two-register 16-bit memory block.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins).
module mem_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] mem_sel,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              winner_q, winner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_sel_q, mem_sel_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              mem_write_q, mem_write_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              grant;
    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign grant = req0 | req1;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it is asking; no history is kept.
    assign pick = ~req0;
`else
    logic last_q, last_d;

    // On a tie the requester not granted last wins; otherwise whoever is asking.
    always_comb begin
        if (req0 && req1) begin
            pick = ~last_q;
        end else begin
            pick = req1;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == StIdle && grant) begin
            last_d = pick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign sel_we    = pick ? we1    : we0;
    assign sel_addr  = pick ? addr1  : addr0;
    assign sel_wdata = pick ? wdata1 : wdata0;

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        we_d        = we_q;
        mem_sel_d   = mem_sel_q;
        mem_din_d   = mem_din_q;
        mem_write_d = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            StIdle: begin
                if (grant) begin
                    winner_d  = pick;
                    we_d      = sel_we;
                    mem_sel_d = sel_addr;
                    // mem_din only follows writes so it holds its last value otherwise
                    if (sel_we) begin
                        mem_din_d   = sel_wdata;
                        mem_write_d = 1'b1;
                    end
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (we_q) begin
                    ack0_d  = ~winner_q;
                    ack1_d  = winner_q;
                    state_d = StResp;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (winner_q) begin
                    rdata1_d = mem_dout;
                end else begin
                    rdata0_d = mem_dout;
                end
                ack0_d  = ~winner_q;
                ack1_d  = winner_q;
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            winner_q    <= 1'b0;
            we_q        <= 1'b0;
            mem_sel_q   <= '0;
            mem_din_q   <= '0;
            mem_write_q <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            we_q        <= we_d;
            mem_sel_q   <= mem_sel_d;
            mem_din_q   <= mem_din_d;
            mem_write_q <= mem_write_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_sel   = mem_sel_q;
    assign mem_write = mem_write_q;
    assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a two-register memory model.
module tb_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_sel;
    logic          mem_write;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    logic [DW-1:0] mem [2] = '{default: '0};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) mem[mem_sel] <= mem_din;
    end
    assign mem_dout = mem[mem_sel];

    mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .ack0     (ack0),
        .rdata0   (rdata0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .ack1     (ack1),
        .rdata1   (rdata1),
        .mem_sel  (mem_sel),
        .mem_write(mem_write),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack0"},  32'(ack0), 32'd0);
        check({tag, "_ack1"},  32'(ack1), 32'd0);
        check({tag, "_mwr"},   32'(mem_write), 32'd0);
        check({tag, "_msel"},  32'(mem_sel), 32'd0);
        check({tag, "_mdin"},  32'(mem_din), 32'd0);
        check({tag, "_rd0"},   32'(rdata0), 32'd0);
        check({tag, "_rd1"},   32'(rdata1), 32'd0);
    endtask

    // Returns which ack fired (0, 1, 2 = both) and how many negedges it took.
    task automatic wait_any_ack(input int limit, output int who, output int waited);
        who = -1;
        waited = 0;
        while (who < 0 && waited < limit) begin
            @(negedge clk);
            waited++;
            if (ack0 && ack1) who = 2;
            else if (ack0) who = 0;
            else if (ack1) who = 1;
        end
        check("ack_seen", 32'(who >= 0), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int who, waited, exp_who, exp_wait;
        logic any_ack;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Write 0x1234 to reg 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 1'b0; wdata0 = 16'h1234;
        @(negedge clk);
        check("w0_mwr",  32'(mem_write), 32'd1);
        check("w0_msel", 32'(mem_sel),   32'd0);
        check("w0_mdin", 32'(mem_din),   32'h1234);
        check("w0_ack_early", 32'(ack0), 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        check("w0_ack",   32'(ack0), 32'd1);
        check("w0_mwr_off", 32'(mem_write), 32'd0);
        @(negedge clk);
        check("w0_ack_pulse", 32'(ack0), 32'd0);
        check("w0_mem", 32'(mem[0]), 32'h1234);

        // Simultaneous writes after reset: requester 0 wins the first tie
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 1'b0; wdata0 = 16'hAAAA;
        req1 = 1'b1; we1 = 1'b1; addr1 = 1'b1; wdata1 = 16'hABCD;
        wait_any_ack(10, who, waited);
        check("sw_first_who", 32'(who), 32'd0);
        check("sw_first_lat", 32'(waited), 32'd2);
        req0 = 1'b0;
        wait_any_ack(10, who, waited);
        check("sw_second_who", 32'(who), 32'd1);
        check("sw_second_gap", 32'(waited), 32'd3);
        req1 = 1'b0;
        check("sw_mem0", 32'(mem[0]), 32'hAAAA);
        check("sw_mem1", 32'(mem[1]), 32'hABCD);

        // Requester 0 reads reg 1
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 1'b1;
        @(negedge clk);
        check("r0_msel", 32'(mem_sel), 32'd1);
        check("r0_mwr",  32'(mem_write), 32'd0);
        wait_any_ack(10, who, waited);
        check("r0_who", 32'(who), 32'd0);
        check("r0_lat", 32'(waited), 32'd2);
        check("r0_rdata0", 32'(rdata0), 32'hABCD);
        check("r0_rdata1", 32'(rdata1), 32'd0);
        req0 = 1'b0;

`ifndef MEM_ARB_FIXED_PRIO_EN
        // Fairness: both hold reads; requester 0 was granted last
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_who  = (i % 2 == 0) ? 1 : 0;
            exp_wait = (i == 0) ? 3 : 4;
            wait_any_ack(10, who, waited);
            check($sformatf("rr%0d_who", i), 32'(who), 32'(exp_who));
            check($sformatf("rr%0d_gap", i), 32'(waited), 32'(exp_wait));
            if (exp_who == 1) check($sformatf("rr%0d_rd1", i), 32'(rdata1), 32'hABCD);
            else check($sformatf("rr%0d_rd0", i), 32'(rdata0), 32'hAAAA);
        end
        req0 = 1'b0;
        req1 = 1'b0;
`else
        // Fixed priority: requester 0 keeps winning until it lets go
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_any_ack(10, who, waited);
            check($sformatf("fp%0d_who", i), 32'(who), 32'd0);
            check($sformatf("fp%0d_rd0", i), 32'(rdata0), 32'hAAAA);
        end
        req0 = 1'b0;
        wait_any_ack(10, who, waited);
        check("fp_req1_who", 32'(who), 32'd1);
        check("fp_req1_rd1", 32'(rdata1), 32'hABCD);
        req1 = 1'b0;
`endif

        // Read back: write 0x1234 to reg 0, then requester 1 reads it
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 1'b0; wdata0 = 16'h1234;
        wait_any_ack(10, who, waited);
        check("rb_w_who", 32'(who), 32'd0);
        check("rb_w_lat", 32'(waited), 32'd2);
        check("rb_w_keeps_rd0", 32'(rdata0), 32'hAAAA);
        req0 = 1'b0;
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 1'b0;
        wait_any_ack(10, who, waited);
        check("rb_r_who", 32'(who), 32'd1);
        check("rb_r_lat", 32'(waited), 32'd3);
        check("rb_r_rd1", 32'(rdata1), 32'h1234);
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        check("rb_hold_rd1", 32'(rdata1), 32'h1234);
        check("rb_hold_ack1", 32'(ack1), 32'd0);

        // Reset in the ACCESS cycle of a write
        req0 = 1'b1; we0 = 1'b1; addr0 = 1'b1; wdata0 = 16'h5555;
        @(negedge clk);
        check("rw_mwr_before", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rw");
        req0 = 1'b0;
        @(negedge clk);
        check("rw_mem1_intact", 32'(mem[1]), 32'hABCD);
        rst_n = 1'b1;
        any_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            any_ack = any_ack | ack0 | ack1;
        end
        check("rw_no_ack", 32'(any_ack), 32'd0);
        req0 = 1'b1; we0 = 1'b1; addr0 = 1'b1; wdata0 = 16'h5555;
        wait_any_ack(10, who, waited);
        check("rw_next_who", 32'(who), 32'd0);
        check("rw_next_lat", 32'(waited), 32'd2);
        check("rw_next_mem1", 32'(mem[1]), 32'h5555);
        req0 = 1'b0;

        // Request dropped mid-transaction still completes
        @(negedge clk);
        req1 = 1'b1; we1 = 1'b0; addr1 = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        wait_any_ack(10, who, waited);
        check("drop_who", 32'(who), 32'd1);
        check("drop_lat", 32'(waited), 32'd2);
        check("drop_rd1", 32'(rdata1), 32'h5555);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
